// File: rtl/divider.sv
// Sequential signed divider: restoring division on operand magnitudes,
// one quotient bit per clock, followed by sign correction. Quotient
// truncates toward zero; the remainder carries the sign of the dividend.
module divider #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     op_start,
    input  logic                     op_clear,
    input  logic signed [DATA_W-1:0] dividend,
    input  logic signed [DATA_W-1:0] divisor,
    output logic signed [DATA_W-1:0] quotient,
    output logic signed [DATA_W-1:0] remainder,
    output logic                     div_by_zero,
    output logic                     op_done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t                     state;
    logic [CNT_W-1:0]           count;
    logic [DATA_W-1:0]          rem_acc;
    logic [DATA_W-1:0]          quo_acc;
    logic [DATA_W-1:0]          dsr_mag;
    logic                       sign_q;
    logic                       sign_r;

    logic [DATA_W-1:0]          rem_shift;
    logic [DATA_W-1:0]          quo_shift;
    logic [DATA_W:0]            trial;
    logic [DATA_W-1:0]          rem_next;
    logic [DATA_W-1:0]          quo_next;

    // Unsigned magnitude; the most negative value maps to 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
        logic [DATA_W-1:0] u;
        u = $unsigned(v);
        return v[DATA_W-1] ? (~u + 1'b1) : u;
    endfunction

    // Two's-complement negation of a magnitude when neg is set (wraps).
    function automatic logic signed [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                           input logic neg);
        logic [DATA_W-1:0] u;
        u = neg ? (~mag + 1'b1) : mag;
        return $signed(u);
    endfunction

    // One restoring-division step: shift {R,Q} left, try subtracting D.
    always_comb begin
        rem_shift = {rem_acc[DATA_W-2:0], quo_acc[DATA_W-1]};
        quo_shift = {quo_acc[DATA_W-2:0], 1'b0};
        trial     = {1'b0, rem_shift} - {1'b0, dsr_mag};
        rem_next  = rem_shift;
        quo_next  = quo_shift;
        if (!trial[DATA_W]) begin
            rem_next = trial[DATA_W-1:0];
            quo_next = quo_shift | {{(DATA_W-1){1'b0}}, 1'b1};
        end
    end

    // Control FSM with registered results; clear beats everything but reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            count       <= '0;
            rem_acc     <= '0;
            quo_acc     <= '0;
            dsr_mag     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            op_done     <= 1'b0;
        end else if (op_clear) begin
            state       <= IDLE;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            op_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    quotient    <= '0;
                    remainder   <= '0;
                    div_by_zero <= 1'b0;
                    op_done     <= 1'b0;
                    if (op_start) begin
                        sign_q  <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
                        sign_r  <= dividend[DATA_W-1];
                        quo_acc <= magnitude(dividend);
                        dsr_mag <= magnitude(divisor);
                        rem_acc <= '0;
                        count   <= '0;
                        if (divisor == '0) begin
                            // Divide by zero resolves immediately with a flagged result.
                            state       <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            op_done     <= 1'b1;
                        end else begin
                            state <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rem_acc <= rem_next;
                    quo_acc <= quo_next;
                    count   <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        state       <= DONE;
                        quotient    <= apply_sign(quo_next, sign_q);
                        remainder   <= apply_sign(rem_next, sign_r);
                        div_by_zero <= 1'b0;
                        op_done     <= 1'b1;
                    end
                end
                DONE: begin
                    op_done <= 1'b1;
                end
                default: begin
                    state       <= IDLE;
                    count       <= '0;
                    quotient    <= '0;
                    remainder   <= '0;
                    div_by_zero <= 1'b0;
                    op_done     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for the sequential signed divider: directed cases,
// control-handshake scenarios and random operands against a plain-arithmetic model.
module tb_divider;

    logic               clk;
    logic               reset_n;
    logic               op_start;
    logic               op_clear;
    logic signed [31:0] dividend;
    logic signed [31:0] divisor;
    logic signed [31:0] quotient;
    logic signed [31:0] remainder;
    logic               div_by_zero;
    logic               op_done;

    int tests_run;
    int tests_failed;

    divider #(.DATA_W(32), .CNT_W(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .op_done     (op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division on wide integers; remainder follows dividend sign.
    task automatic model(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        longint sa, sb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
            z = 1'b1;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lq = sa / sb;
            lr = sa % sb;
            q  = lq[31:0];
            r  = lr[31:0];
            z  = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_q"}, quotient, 32'd0);
        check({tag, "_r"}, remainder, 32'd0);
        check({tag, "_flags"}, {30'd0, div_by_zero, op_done}, 32'd0);
    endtask

    // Start an operation, confirm outputs stay quiet, then check the result.
    task automatic start_and_wait(input string tag, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eq, er;
        logic        ez;
        logic        early;
        model(a, b, eq, er, ez);
        dividend = a;
        divisor  = b;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        if (!ez) begin
            early = 1'b0;
            for (int i = 0; i < 31; i++) begin
                if (op_done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) early = 1'b1;
                tick();
            end
            if (op_done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) early = 1'b1;
            check({tag, "_quiet"}, {31'd0, early}, 32'd0);
            tick();
        end
        check({tag, "_done"}, {31'd0, op_done}, 32'd1);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    endtask

    task automatic do_clear(input string tag);
        op_clear = 1'b1;
        tick();
        op_clear = 1'b0;
        check_idle(tag);
    endtask

    initial begin
        logic [31:0] ra, rb, hq, hr;
        logic        never;
        tests_run    = 0;
        tests_failed = 0;
        reset_n  = 1'b0;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) tick();
        check_idle("reset");
        reset_n = 1'b1;
        tick();
        check_idle("post_reset");

        // Basic and sign cases
        start_and_wait("d100_7", 32'd100, 32'd7);
        do_clear("clr1");
        start_and_wait("dm100_7", -32'sd100, 32'd7);
        do_clear("clr2");
        start_and_wait("d100_m7", 32'd100, -32'sd7);
        do_clear("clr3");
        start_and_wait("dm100_m7", -32'sd100, -32'sd7);
        do_clear("clr4");

        // Divide by zero resolves after one edge
        start_and_wait("dz1234", 32'd1234, 32'd0);
        do_clear("clr_dz");

        // Boundaries
        start_and_wait("ovf", 32'h8000_0000, 32'hFFFF_FFFF);
        do_clear("clr5");
        start_and_wait("min_1", 32'h8000_0000, 32'd1);
        do_clear("clr6");
        start_and_wait("d7_9", 32'd7, 32'd9);
        do_clear("clr7");
        start_and_wait("m1_max", 32'hFFFF_FFFF, 32'h7FFF_FFFF);
        do_clear("clr8");

        // Abort at the 10th EXEC cycle, then confirm nothing completes
        dividend = 32'd1000;
        divisor  = 32'd3;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (9) tick();
        do_clear("abort");
        never = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (op_done !== 1'b0) never = 1'b1;
            tick();
        end
        check("abort_no_done", {31'd0, never}, 32'd0);
        start_and_wait("d6_3", 32'd6, 32'd3);

        // op_start held in DONE must not restart or disturb outputs
        op_start = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        hq = quotient;
        hr = remainder;
        never = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (op_done !== 1'b1 || quotient !== 32'd2 || remainder !== 32'd0) never = 1'b1;
        end
        op_start = 1'b0;
        check("done_hold", {31'd0, never}, 32'd0);
        do_clear("clr9");

        // Simultaneous start and clear in IDLE stays IDLE
        dividend = 32'd50;
        divisor  = 32'd5;
        op_start = 1'b1;
        op_clear = 1'b1;
        tick();
        op_start = 1'b0;
        op_clear = 1'b0;
        check_idle("start_clr");
        never = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (op_done !== 1'b0) never = 1'b1;
        end
        check("start_clr_idle", {31'd0, never}, 32'd0);

        // Asynchronous reset during EXEC
        dividend = 32'h7FFF_FFFF;
        divisor  = 32'd3;
        op_start = 1'b1;
        tick();
        op_start = 1'b0;
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1 check_idle("arst_exec");
        reset_n = 1'b1;
        never = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (op_done !== 1'b0) never = 1'b1;
        end
        check("arst_exec_abort", {31'd0, never}, 32'd0);

        // Asynchronous reset while holding a result in DONE
        start_and_wait("d50_5a", 32'd50, 32'd5);
        #2 reset_n = 1'b0;
        #1 check_idle("arst_done");
        reset_n = 1'b1;
        tick();
        start_and_wait("d50_5", 32'd50, 32'd5);
        do_clear("clr10");

        // Random operands, mixing full-range and small divisors
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = -$urandom_range(1, 20);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if (rb == 32'd0) rb = 32'd1;
            start_and_wait($sformatf("rnd%0d", i), ra, rb);
            do_clear($sformatf("rclr%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
